// File: rtl/lms_conv_monitor.sv
// lms_conv_monitor: convergence observer for the 16-tap DA-LMS filter.
// Squares each enabled 12-bit error sample, averages over a window of
// 2**WIN_LOG2 samples and classifies adaptation as ACQ / CONV / DIV.
// Optional build macro LMS_MON_PEAK_EN adds a per-window peak |errr| output.
module lms_conv_monitor #(
  parameter int unsigned WIN_LOG2 = 5,
  parameter int unsigned CONV_THR = 64,
  parameter int unsigned DIV_THR  = 262144,
  parameter int unsigned HOLD     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [11:0] errr,
  output logic [22:0] mse,
  output logic        win_done,
  output logic        converged,
  output logic        diverged,
  output logic [1:0]  state
`ifdef LMS_MON_PEAK_EN
  ,
  output logic [11:0] peak
`endif
);

  localparam int unsigned ACC_W = 23 + WIN_LOG2;

  typedef enum logic [1:0] {
    ST_ACQ  = 2'b00,
    ST_CONV = 2'b01,
    ST_DIV  = 2'b10
  } st_t;

  st_t                 st;
  logic [11:0]         mag;
  logic [22:0]         mag23;
  logic [22:0]         sq_d;
  logic [22:0]         sq;
  logic                sq_v;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    wsum;
  logic [WIN_LOG2-1:0] cnt;
  logic                end_p;
  logic [22:0]         mse_new;
  logic [31:0]         mse32;
  logic [3:0]          good;

  // Magnitude and exact square of the incoming error; -2048 maps to 2048
  always_comb begin
    mag     = errr[11] ? (~errr + 12'd1) : errr;
    mag23   = {11'd0, mag};
    sq_d    = mag23 * mag23;
    mse_new = 23'(wsum >> WIN_LOG2);
    mse32   = {9'd0, mse_new};
  end

  // Stage 1: register the square; valid follows en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq   <= '0;
      sq_v <= 1'b0;
    end else if (clr) begin
      sq   <= '0;
      sq_v <= 1'b0;
    end else begin
      sq_v <= en;
      if (en) sq <= sq_d;
    end
  end

  // Stage 2: accumulate; the final sum is parked in wsum so acc can start
  // the next window on the very next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      wsum  <= '0;
      cnt   <= '0;
      end_p <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      cnt   <= '0;
      end_p <= 1'b0;
    end else begin
      end_p <= 1'b0;
      if (sq_v) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          wsum  <= acc + ACC_W'(sq);
          acc   <= '0;
          end_p <= 1'b1;
        end else begin
          acc <= acc + ACC_W'(sq);
        end
      end
    end
  end

  // Stage 3: publish MSE and advance the classification FSM at window end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mse       <= '0;
      win_done  <= 1'b0;
      st        <= ST_ACQ;
      converged <= 1'b0;
      diverged  <= 1'b0;
      good      <= '0;
    end else if (clr) begin
      win_done  <= 1'b0;
      st        <= ST_ACQ;
      converged <= 1'b0;
      diverged  <= 1'b0;
      good      <= '0;
    end else begin
      win_done <= end_p;
      if (end_p) begin
        mse <= mse_new;
        case (st)
          ST_ACQ: begin
            if (mse32 >= DIV_THR) begin
              st        <= ST_DIV;
              diverged  <= 1'b1;
              converged <= 1'b0;
            end else if (mse32 <= CONV_THR) begin
              if ({28'd0, good} + 32'd1 >= HOLD) begin
                good      <= 4'(HOLD);
                st        <= ST_CONV;
                converged <= 1'b1;
                diverged  <= 1'b0;
              end else begin
                good <= good + 4'd1;
              end
            end else begin
              good <= '0;
            end
          end
          ST_CONV: begin
            if (mse32 >= DIV_THR) begin
              st        <= ST_DIV;
              diverged  <= 1'b1;
              converged <= 1'b0;
            end else if (mse32 > CONV_THR) begin
              st        <= ST_ACQ;
              good      <= '0;
              converged <= 1'b0;
              diverged  <= 1'b0;
            end
          end
          ST_DIV: begin
            st        <= ST_DIV;
            diverged  <= 1'b1;
            converged <= 1'b0;
          end
          default: begin
            st        <= ST_ACQ;
            good      <= '0;
            converged <= 1'b0;
            diverged  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st;

`ifdef LMS_MON_PEAK_EN
  logic [WIN_LOG2-1:0] cnt1;
  logic [11:0]         pk_run;
  logic [11:0]         pk_win;

  // Running peak tracked in stage 1 with its own sample counter, which stays
  // in lockstep with the stage-2 counter; pk_win is stable until win_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1   <= '0;
      pk_run <= '0;
      pk_win <= '0;
    end else if (clr) begin
      cnt1   <= '0;
      pk_run <= '0;
      pk_win <= '0;
    end else if (en) begin
      cnt1 <= cnt1 + 1'b1;
      if (cnt1 == '1) begin
        pk_win <= (mag > pk_run) ? mag : pk_run;
        pk_run <= '0;
      end else if (mag > pk_run) begin
        pk_run <= mag;
      end
    end
  end

  // Publish the peak alongside mse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (clr) begin
      peak <= '0;
    end else if (end_p) begin
      peak <= pk_win;
    end
  end
`endif

endmodule

// File: tb/tb_lms_conv_monitor.sv
// Directed bench for lms_conv_monitor: window vectors from a table plus
// hand sequences for reset mid-stream and clear on the window-end cycle.
module tb_lms_conv_monitor;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [11:0] errr;
  logic [22:0] mse;
  logic        win_done;
  logic        converged;
  logic        diverged;
  logic [1:0]  state;
`ifdef LMS_MON_PEAK_EN
  logic [11:0] peak;
`endif

  int checks = 0;
  int errors = 0;

  lms_conv_monitor #(
    .WIN_LOG2(5),
    .CONV_THR(64),
    .DIV_THR(262144),
    .HOLD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .errr(errr),
    .mse(mse),
    .win_done(win_done),
    .converged(converged),
    .diverged(diverged),
    .state(state)
`ifdef LMS_MON_PEAK_EN
    ,
    .peak(peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       a;
    int       b;
    bit       tog;
    int       exp_mse;
    int       exp_st;
    int       exp_pk;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one window of 32 enabled samples (a on even, b on odd index,
  // sval at index sidx); returns at the negedge after edge k+1
  task automatic run_window(input int a, input int b, input bit tog,
                            input int sidx, input int sval);
    int spur;
    int v;
    spur = 0;
    for (int i = 0; i < 32; i++) begin
      if (tog) begin
        @(negedge clk);
        if (win_done) spur++;
        en = 1'b0;
      end
      @(negedge clk);
      if (win_done) spur++;
      en = 1'b1;
      v = (i == sidx) ? sval : ((i % 2 == 1) ? b : a);
      errr = v[11:0];
    end
    @(negedge clk);
    if (win_done) spur++;
    en = 1'b0;
    errr = '0;
    @(negedge clk);
    chk("win_done_early", int'(win_done), 0);
    chk("no_spurious_pulse", spur, 0);
  endtask

  task automatic check_result(input int exp_mse, input int exp_st, input int exp_pk);
    @(negedge clk);
    chk("win_done", int'(win_done), 1);
    chk("mse", int'(mse), exp_mse);
    chk("state", int'(state), exp_st);
    chk("converged", int'(converged), (exp_st == 1) ? 1 : 0);
    chk("diverged", int'(diverged), (exp_st == 2) ? 1 : 0);
`ifdef LMS_MON_PEAK_EN
    chk("peak", int'(peak), exp_pk);
`else
    if (exp_pk < 0) chk("peak_arg", exp_pk, 0);
`endif
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, "_mse"}, int'(mse), 0);
    chk({nm, "_win_done"}, int'(win_done), 0);
    chk({nm, "_state"}, int'(state), 0);
    chk({nm, "_conv"}, int'(converged), 0);
    chk({nm, "_div"}, int'(diverged), 0);
  endtask

  initial begin
    tv[0]  = '{16,    16,    1'b0, 256,     0, 16};
    tv[1]  = '{4,     4,     1'b0, 16,      0, 4};
    tv[2]  = '{4,     4,     1'b0, 16,      0, 4};
    tv[3]  = '{4,     4,     1'b0, 16,      0, 4};
    tv[4]  = '{4,     4,     1'b0, 16,      1, 4};
    tv[5]  = '{4,     4,     1'b0, 16,      1, 4};
    tv[6]  = '{16,    16,    1'b0, 256,     0, 16};
    tv[7]  = '{3,     -5,    1'b0, 17,      0, 5};
    tv[8]  = '{-8,    8,     1'b0, 64,      0, 8};
    tv[9]  = '{0,     0,     1'b0, 0,       0, 0};
    tv[10] = '{8,     8,     1'b1, 64,      1, 8};
    tv[11] = '{9,     9,     1'b0, 81,      0, 9};
    tv[12] = '{511,   511,   1'b0, 261121,  0, 511};
    tv[13] = '{512,   512,   1'b0, 262144,  2, 512};
    tv[14] = '{0,     0,     1'b0, 0,       2, 0};
    tv[15] = '{-2048, -2048, 1'b0, 4194304, 2, 2048};

    rst = 1'b1;
    en = 1'b0;
    clr = 1'b0;
    errr = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    // Reset mid-stream: a completed window, then a partial one lost to rst
    run_window(100, 100, 1'b0, -1, 0);
    check_result(10000, 0, 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en = 1'b1;
      errr = 12'd100;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_zero("rst_async");
    en = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_held");
    rst = 1'b0;
    run_window(4, 4, 1'b0, -1, 0);
    check_result(16, 0, 4);

    for (int k = 0; k < 16; k++) begin
      run_window(tv[k].a, tv[k].b, tv[k].tog, -1, 0);
      check_result(tv[k].exp_mse, tv[k].exp_st, tv[k].exp_pk);
    end

    // Clear lands on the window-end edge: window discarded, mse held, DIV left
    run_window(3, 3, 1'b0, 10, -100);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_win_done", int'(win_done), 0);
    chk("clr_mse_hold", int'(mse), 4194304);
    chk("clr_state", int'(state), 0);
    chk("clr_diverged", int'(diverged), 0);
`ifdef LMS_MON_PEAK_EN
    chk("clr_peak", int'(peak), 0);
`endif
    repeat (3) begin
      @(negedge clk);
      chk("clr_no_late_pulse", int'(win_done), 0);
    end

    run_window(3, 3, 1'b0, 10, -100);
    check_result(321, 0, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
